// File: rtl/ffexp_seq.sv
// ffexp_seq: iterative GF(2^m) exponentiator, MSB-first square-and-multiply
// around one shared combinational field multiplier.
module ffexp_seq #(
    parameter int DATA_WIDTH = 32
) (
    input  logic                  clk,
    input  logic                  rst_l,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic [5:0]            polyn_grade,
    input  logic [DATA_WIDTH:0]   polyn_red_in,
    input  logic [DATA_WIDTH-1:0] base,
    input  logic [DATA_WIDTH-1:0] exp,
    input  logic                  kill,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [DATA_WIDTH-1:0] out_data,
    output logic                  busy
);
    typedef enum logic [1:0] {IDLE, SQR, MUL, DONE} state_t;

    state_t                state_q, state_d;
    logic [DATA_WIDTH-1:0] acc_q, acc_d, base_q, base_d, exp_q, exp_d, prod;
    logic [4:0]            idx_q, idx_d;
    logic [5:0]            grade_q, grade_d;
    logic [DATA_WIDTH:0]   poly_q, poly_d;

    // Operand bits at or above the field degree are ignored.
    function automatic logic [DATA_WIDTH-1:0] ffmul(
        input logic [DATA_WIDTH-1:0] a,
        input logic [DATA_WIDTH-1:0] b,
        input logic [5:0]            m,
        input logic [DATA_WIDTH:0]   p
    );
        logic [DATA_WIDTH:0]   r;
        logic [DATA_WIDTH-1:0] mask;
        mask = (m >= 6'd32) ? '1 : ((32'd1 << m) - 32'd1);
        r = '0;
        for (int i = DATA_WIDTH - 1; i >= 0; i--) begin
            r = r << 1;
            if (r[m]) r = r ^ p;
            if (b[i] & mask[i]) r = r ^ {1'b0, a & mask};
        end
        return r[DATA_WIDTH-1:0];
    endfunction

    assign prod      = ffmul(acc_q, (state_q == MUL) ? base_q : acc_q, grade_q, poly_q);
    assign in_ready  = (state_q == IDLE) & rst_l;
    assign out_valid = (state_q == DONE);
    assign out_data  = (state_q == DONE) ? acc_q : '0;
    assign busy      = (state_q == SQR) | (state_q == MUL);

    always_ff @(posedge clk) begin
        if (!rst_l) begin
            state_q <= IDLE;
            acc_q   <= '0;
            idx_q   <= '0;
            grade_q <= '0;
            poly_q  <= '0;
            base_q  <= '0;
            exp_q   <= '0;
        end else begin
            state_q <= state_d;
            acc_q   <= acc_d;
            idx_q   <= idx_d;
            grade_q <= grade_d;
            poly_q  <= poly_d;
            base_q  <= base_d;
            exp_q   <= exp_d;
        end
    end

    always_comb begin
        state_d = state_q;
        acc_d   = acc_q;
        idx_d   = idx_q;
        grade_d = grade_q;
        poly_d  = poly_q;
        base_d  = base_q;
        exp_d   = exp_q;
        case (state_q)
            IDLE: if (in_valid) begin
                grade_d = polyn_grade;
                poly_d  = polyn_red_in;
                base_d  = base;
                exp_d   = exp;
                acc_d   = 32'd1;
                idx_d   = 5'd31;
                state_d = SQR;
            end
            SQR: begin
                acc_d = prod;
                if (exp_q[idx_q]) state_d = MUL;
                else if (idx_q == 5'd0) state_d = DONE;
                else idx_d = idx_q - 5'd1;
            end
            MUL: begin
                acc_d = prod;
                if (idx_q == 5'd0) state_d = DONE;
                else begin
                    idx_d   = idx_q - 5'd1;
                    state_d = SQR;
                end
            end
            DONE: if (out_ready) state_d = IDLE;
        endcase
        // Abort wins over accept and over result hand-off.
        if (kill) begin
            state_d = IDLE;
            acc_d   = '0;
        end
    end
endmodule
